// File: rtl/sequencer_pkg.sv
// Shared types for the step-sequencer: note encoding and the pattern-editor
// state type. The audio controller takes note_t from here as well.
package sequencer_pkg;

   localparam int NOTE_W = 4;
   typedef logic [NOTE_W-1:0] note_t;

   localparam note_t NOTE_REST = 4'd0;
   localparam note_t NOTE_MAX  = 4'd15;

   typedef enum logic {EDIT_IDLE, EDIT_CLEAR} edit_state_t;

   // Bit positions of the five front-panel buttons in the pulse vector.
   localparam int BTN_CLEAR = 0;
   localparam int BTN_NEXT  = 1;
   localparam int BTN_PREV  = 2;
   localparam int BTN_UP    = 3;
   localparam int BTN_DOWN  = 4;
   localparam int NUM_BTNS  = 5;

   // One saturating pitch step: up stops at NOTE_MAX, down stops at NOTE_REST.
   function automatic note_t note_step(input note_t n, input logic up);
      if (up) return (n == NOTE_MAX)  ? n : n + 1'b1;
      else    return (n == NOTE_REST) ? n : n - 1'b1;
   endfunction

endpackage

// File: rtl/pattern_editor_if.sv
// Front-panel / controller bundle of the pattern editor.
//   btn_next/prev/up/down/clear : raw asynchronous buttons
//   beat_count                  : playhead step from the audio controller
//   beats, cursor, cursor_pitch : pattern and edit position
//   on_playhead, busy           : LED / status outputs
// slave = pattern editor side, master = panel/controller side.
interface pattern_editor_if
   import sequencer_pkg::*;
#(
   parameter int NUM_BEATS = 16
);
   localparam int IDX_W = $clog2(NUM_BEATS);

   logic                        btn_next;
   logic                        btn_prev;
   logic                        btn_up;
   logic                        btn_down;
   logic                        btn_clear;
   logic [IDX_W-1:0]            beat_count;
   logic [NUM_BEATS*NOTE_W-1:0] beats;
   logic [IDX_W-1:0]            cursor;
   note_t                       cursor_pitch;
   logic                        on_playhead;
   logic                        busy;

   modport master (
      output btn_next, btn_prev, btn_up, btn_down, btn_clear, beat_count,
      input  beats, cursor, cursor_pitch, on_playhead, busy
   );

   modport slave (
      input  btn_next, btn_prev, btn_up, btn_down, btn_clear, beat_count,
      output beats, cursor, cursor_pitch, on_playhead, busy
   );

endinterface

// File: rtl/button_debouncer.sv
// Synchronises and debounces one raw button and emits a one-cycle pulse on
// each accepted press (release produces nothing).
//   clk, rst    : clock, async active-high reset
//   btn_raw     : raw asynchronous button level
//   level       : debounced level
//   press_pulse : one-cycle pulse after the debounced 0->1 edge
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 120_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic press_pulse
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync1;
   logic             sync2;
   logic             stable;
   logic             stable_q;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1       <= 1'b0;
         sync2       <= 1'b0;
         stable      <= 1'b0;
         stable_q    <= 1'b0;
         press_pulse <= 1'b0;
         cnt         <= '0;
      end else begin
         sync1       <= btn_raw;
         sync2       <= sync1;
         stable_q    <= stable;
         // Registered so the pulse lands one cycle after the stable flip.
         press_pulse <= stable & ~stable_q;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable <= ~stable;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign level = stable;

endmodule

// File: rtl/pattern_editor.sv
// Owns the step-sequencer pattern and applies front-panel edits to it:
// cursor next/prev, pitch up/down at the cursor, and a one-step-per-cycle
// clear sweep of the whole pattern.
//   clk, rst : clock, async active-high reset
//   bus      : pattern_editor_if.slave (buttons, beat_count in; pattern,
//              cursor, cursor_pitch, on_playhead, busy out)
module pattern_editor
   import sequencer_pkg::*;
#(
   parameter int                             CLK_FREQ        = 12_000_000,
   parameter int                             NUM_BEATS       = 16,
   parameter int                             DEBOUNCE_CYCLES = CLK_FREQ / 100,
   parameter logic [NUM_BEATS*NOTE_W-1:0]    INIT_PATTERN    = '0
) (
   input logic              clk,
   input logic              rst,
   pattern_editor_if.slave  bus
);

   localparam int IDX_W = $clog2(NUM_BEATS);
   localparam int PAT_W = NUM_BEATS * NOTE_W;

   logic [NUM_BTNS-1:0] btn_raw;
   logic [NUM_BTNS-1:0] pulse;
   // Debounced levels are available but edits act on press pulses only.
   logic [NUM_BTNS-1:0] unused_levels;

   assign btn_raw[BTN_CLEAR] = bus.btn_clear;
   assign btn_raw[BTN_NEXT]  = bus.btn_next;
   assign btn_raw[BTN_PREV]  = bus.btn_prev;
   assign btn_raw[BTN_UP]    = bus.btn_up;
   assign btn_raw[BTN_DOWN]  = bus.btn_down;

   for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
      button_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk        (clk),
         .rst        (rst),
         .btn_raw    (btn_raw[b]),
         .level      (unused_levels[b]),
         .press_pulse(pulse[b])
      );
   end

   edit_state_t      state, state_next;
   logic [PAT_W-1:0] beats_q, beats_d;
   logic [IDX_W-1:0] cursor_q, cursor_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   note_t            cur_note;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= EDIT_IDLE;
         beats_q  <= INIT_PATTERN;
         cursor_q <= '0;
         idx_q    <= '0;
      end else begin
         state    <= state_next;
         beats_q  <= beats_d;
         cursor_q <= cursor_d;
         idx_q    <= idx_d;
      end
   end

   assign cur_note = beats_q[cursor_q*NOTE_W +: NOTE_W];

   always_comb begin
      state_next = state;
      beats_d    = beats_q;
      cursor_d   = cursor_q;
      idx_d      = idx_q;
      case (state)
         EDIT_IDLE: begin
            // Fixed priority; lower-priority pulses in the same cycle are lost.
            if (pulse[BTN_CLEAR]) begin
               idx_d      = '0;
               state_next = EDIT_CLEAR;
            end else if (pulse[BTN_NEXT]) begin
               cursor_d = cursor_q + 1'b1;
            end else if (pulse[BTN_PREV]) begin
               cursor_d = cursor_q - 1'b1;
            end else if (pulse[BTN_UP]) begin
               beats_d[cursor_q*NOTE_W +: NOTE_W] = note_step(cur_note, 1'b1);
            end else if (pulse[BTN_DOWN]) begin
               beats_d[cursor_q*NOTE_W +: NOTE_W] = note_step(cur_note, 1'b0);
            end
         end
         EDIT_CLEAR: begin
            // Pulses arriving here are simply ignored.
            beats_d[idx_q*NOTE_W +: NOTE_W] = NOTE_REST;
            idx_d = idx_q + 1'b1;
            if (idx_q == IDX_W'(NUM_BEATS - 1)) state_next = EDIT_IDLE;
         end
         default: state_next = EDIT_IDLE;
      endcase
   end

   assign bus.beats        = beats_q;
   assign bus.cursor       = cursor_q;
   assign bus.cursor_pitch = cur_note;
   assign bus.on_playhead  = (cursor_q == bus.beat_count);
   assign bus.busy         = (state == EDIT_CLEAR);

endmodule

// File: tb/tb_pattern_editor.sv
module tb_pattern_editor;
   import sequencer_pkg::*;

   localparam int NB = 16;
   localparam int D  = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pattern_editor_if #(.NUM_BEATS(NB)) bus();

   pattern_editor #(
      .CLK_FREQ       (12_000_000),
      .NUM_BEATS      (NB),
      .DEBOUNCE_CYCLES(D),
      .INIT_PATTERN   ('0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A press is accepted when D consecutive raw samples, seen through a
   // two-stage synchroniser, disagree with the accepted level; the edit
   // happens two edges after acceptance.
   int          m_notes [NB];
   int          m_cursor, m_idx;
   bit          m_busy;
   logic [D:0]  hist [NUM_BTNS];   // bit j = raw sample j+1 edges ago
   logic [NUM_BTNS-1:0] m_stable, r1, r2, act, raw_now;
   logic        all_diff;

   task automatic m_reset();
      foreach (m_notes[k]) m_notes[k] = 0;
      m_cursor = 0; m_idx = 0; m_busy = 0;
      foreach (hist[b]) hist[b] = '0;
      m_stable = '0; r1 = '0; r2 = '0;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_reset();
      end else begin
         raw_now = {bus.btn_down, bus.btn_up, bus.btn_prev, bus.btn_next, bus.btn_clear};
         act = r2;
         r2  = r1;
         for (int b = 0; b < NUM_BTNS; b++) begin
            all_diff = 1'b1;
            for (int j = 1; j <= D; j++)
               if (hist[b][j] == m_stable[b]) all_diff = 1'b0;
            r1[b] = 1'b0;
            if (all_diff) begin
               m_stable[b] = ~m_stable[b];
               r1[b] = m_stable[b];
            end
            hist[b] = {hist[b][D-1:0], raw_now[b]};
         end
         if (m_busy) begin
            m_notes[m_idx] = 0;
            m_idx++;
            if (m_idx == NB) m_busy = 0;
         end else if (act[0]) begin
            m_busy = 1; m_idx = 0;
         end else if (act[1]) m_cursor = (m_cursor + 1) % NB;
         else if (act[2]) m_cursor = (m_cursor + NB - 1) % NB;
         else if (act[3]) begin
            if (m_notes[m_cursor] < 15) m_notes[m_cursor]++;
         end else if (act[4]) begin
            if (m_notes[m_cursor] > 0) m_notes[m_cursor]--;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [63:0] m_beats;
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         for (int k = 0; k < NB; k++) m_beats[k*4 +: 4] = 4'(m_notes[k]);
         check("beats",        bus.beats,                m_beats);
         check("cursor",       64'(bus.cursor),          64'(m_cursor));
         check("cursor_pitch", 64'(bus.cursor_pitch),    64'(m_notes[m_cursor]));
         check("on_playhead",  64'(bus.on_playhead),     64'(m_cursor == int'(bus.beat_count)));
         check("busy",         64'(bus.busy),            64'(m_busy));
      end
   end

   // ---------------- stimulus ----------------
   // mask bits: 0 clear, 1 next, 2 prev, 3 up, 4 down
   task automatic set_btns(input logic [4:0] m);
      bus.btn_clear = m[0];
      bus.btn_next  = m[1];
      bus.btn_prev  = m[2];
      bus.btn_up    = m[3];
      bus.btn_down  = m[4];
   endtask

   task automatic press(input logic [4:0] m, input int hold);
      @(negedge clk);
      set_btns(m);
      repeat (hold) @(negedge clk);
      set_btns('0);
      repeat (D + 6) @(negedge clk);
   endtask

   int busy_cnt;
   int waited;

   initial begin
      rst = 1'b1;
      set_btns('0);
      bus.beat_count = '0;
      repeat (3) @(negedge clk);
      check("reset_beats",  bus.beats,          64'h0);
      check("reset_cursor", 64'(bus.cursor),    64'h0);
      check("reset_busy",   64'(bus.busy),      64'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Clean up press: update lands exactly at edge D+3 = 7.
      @(negedge clk);
      set_btns(5'b01000);
      repeat (7) @(negedge clk);
      check("up_edge6_step0", 64'(bus.beats[3:0]), 64'h0);
      @(negedge clk);
      check("up_edge7_step0", 64'(bus.beats[3:0]), 64'h1);
      repeat (12) @(negedge clk);
      set_btns('0);
      repeat (12) @(negedge clk);
      check("held_once_step0", 64'(bus.beats[3:0]), 64'h1);
      check("held_pitch",      64'(bus.cursor_pitch), 64'h1);

      // Glitches shorter than the debounce window.
      for (int g = 1; g <= 3; g++) press(5'b01000, g);
      check("glitch_beats", bus.beats, 64'h1);

      // Cursor wrap both ways.
      press(5'b00100, 6);
      check("prev_wrap", 64'(bus.cursor), 64'd15);
      press(5'b00010, 6);
      check("next_wrap", 64'(bus.cursor), 64'd0);

      // Saturation high on step 5, low on step 3.
      repeat (5) press(5'b00010, 6);
      repeat (16) press(5'b01000, 6);
      check("sat_hi_step5", 64'(bus.beats[23:20]), 64'hF);
      repeat (2) press(5'b00100, 6);
      press(5'b10000, 6);
      check("sat_lo_step3", 64'(bus.beats[15:12]), 64'h0);

      // Playhead comparison at cursor 3.
      bus.beat_count = 4'd3;
      #1 check("playhead_eq", 64'(bus.on_playhead), 64'h1);
      bus.beat_count = 4'd4;
      #1 check("playhead_ne", 64'(bus.on_playhead), 64'h0);

      // Simultaneous next+up: next wins.
      press(5'b01010, 6);
      check("prio_next_cursor", 64'(bus.cursor), 64'd4);
      check("prio_next_beats",  bus.beats, 64'h0000_0000_00F0_0001);

      // Simultaneous clear+up: clear wins, cursor untouched.
      press(5'b01001, 6);
      repeat (20) @(negedge clk);
      check("prio_clear_beats",  bus.beats, 64'h0);
      check("prio_clear_cursor", 64'(bus.cursor), 64'd4);

      // Build 0xFEDCBA9876543210 by hand edits.
      repeat (4) press(5'b00100, 6);
      for (int k = 0; k < NB; k++) begin
         repeat (k) press(5'b01000, 6);
         press(5'b00010, 6);
      end
      check("ramp_pattern", bus.beats, 64'hFEDC_BA98_7654_3210);

      // Clear sweep with an up press landing while busy.
      @(negedge clk);
      set_btns(5'b00001);
      repeat (6) @(negedge clk);
      set_btns(5'b01001);
      busy_cnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (i == 10) set_btns('0);
         if (bus.busy) busy_cnt++;
      end
      check("clear_busy_cycles", 64'(busy_cnt), 64'd16);
      check("clear_beats",       bus.beats, 64'h0);

      // Reset in the middle of a sweep.
      repeat (10) press(5'b00010, 6);
      repeat (2) press(5'b01000, 6);
      check("pre_reset_pattern", bus.beats, 64'h0000_0200_0000_0000);
      @(negedge clk);
      set_btns(5'b00001);
      waited = 0;
      while (bus.busy !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("busy_seen", 64'(bus.busy), 64'h1);
      repeat (7) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midclear_rst_beats",  bus.beats,       64'h0);
      check("midclear_rst_busy",   64'(bus.busy),   64'h0);
      check("midclear_rst_cursor", 64'(bus.cursor), 64'h0);
      set_btns('0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("post_reset_beats", bus.beats, 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pattern_editor.md
Name: pattern_editor

Overview:
- Upstream stage of the audio controller; owns the step-sequencer pattern register `beats`, which the controller reads one 4-bit pitch per step.
- Turns five raw front-panel buttons into edit operations on that pattern.
- Edit operations: move cursor, raise/lower the pitch at the cursor, clear the whole pattern.
- Also exports cursor/playhead information for LEDs.

Parameters:
- CLK_FREQ, 12_000_000, system clock in Hz.
- NUM_BEATS, 16, pattern steps (power of two, >=2).
- DEBOUNCE_CYCLES, CLK_FREQ/100, stable cycles required to accept a button level change (10 ms default).
- INIT_PATTERN, '0 (NUM_BEATS*4 bits), pattern loaded on reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- btn_next  in  1  raw, asynchronous; cursor +1.
- btn_prev  in  1  raw, asynchronous; cursor -1.
- btn_up  in  1  raw, asynchronous; pitch +1 at cursor.
- btn_down  in  1  raw, asynchronous; pitch -1 at cursor.
- btn_clear  in  1  raw, asynchronous; zero whole pattern.
- beat_count  in  $clog2(NUM_BEATS)  current playhead step from the audio controller.
- beats  out  NUM_BEATS*4  pattern; step i is beats[i*4 +: 4]; 0 = rest.
- cursor  out  $clog2(NUM_BEATS)  step being edited.
- cursor_pitch  out  4  beats[cursor*4 +: 4], combinational.
- on_playhead  out  1  (cursor == beat_count), combinational.
- busy  out  1  high while a clear sweep is running.

Behaviour:
- Reset (async assert, sync release): beats=INIT_PATTERN, cursor=0, busy=0, state=IDLE, all debouncers stable=0, counters=0.
- Button front end, per button:
  - 2-FF synchroniser.
  - Debounce counter counts while synchronised level != stable level; resets to 0 on any cycle they match.
  - When the count reaches DEBOUNCE_CYCLES-1, stable flips and the counter clears.
  - A one-cycle press pulse is produced on the stable 0->1 edge only; the release edge produces no pulse.
  - Glitches shorter than DEBOUNCE_CYCLES produce nothing.
- Latency: a clean press first sampled at edge 0 yields its pulse at edge DEBOUNCE_CYCLES+2 and the register update at edge DEBOUNCE_CYCLES+3.
- Holding a button gives exactly one action; there is no auto-repeat.
- IDLE state, at most one action per cycle. Fixed priority, highest first: clear, next, prev, up, down. Lower-priority pulses in the same cycle are dropped, not queued.
  - next: cursor <= cursor+1, wraps NUM_BEATS-1 -> 0.
  - prev: cursor <= cursor-1, wraps 0 -> NUM_BEATS-1.
  - up: step[cursor] <= min(step+1, 15); saturates at 15.
  - down: step[cursor] <= max(step-1, 0); saturates at 0.
  - clear: busy<=1, clear index idx<=0, go to CLEAR. Cursor unchanged.
- CLEAR state:
  - Each cycle: step[idx] <= 0, idx <= idx+1.
  - After writing step NUM_BEATS-1: busy<=0, return to IDLE.
  - busy is high for exactly NUM_BEATS cycles.
  - All press pulses arriving during CLEAR are discarded.
- Reset mid-CLEAR: immediate return to IDLE with beats=INIT_PATTERN; the partially cleared pattern is not retained.
- beats changes only on the edits above; it is never written from beat_count.
- The downstream controller samples beats freely; a torn mid-CLEAR pattern is acceptable.

Decomposition:
- Package sequencer_pkg:
  - NOTE_W=4, NOTE_REST=4'd0, NOTE_MAX=4'd15.
  - typedef logic [NOTE_W-1:0] note_t.
  - typedef enum logic {EDIT_IDLE, EDIT_CLEAR} edit_state_t.
  - The audio controller adopts note_t from this package.
- Sub-module button_debouncer:
  - Parameter DEBOUNCE_CYCLES.
  - Ports clk, rst, btn_raw, level, press_pulse.
  - Instantiated five times.

Test Plan (DEBOUNCE_CYCLES=4, NUM_BEATS=16, INIT_PATTERN=0):
- Reset, then a clean btn_up press held 20 cycles -> step0 becomes 1 exactly at edge 7 after first sample, then no further change; cursor_pitch=1.
- Glitches on btn_up of 1, 2 and 3 cycles -> beats unchanged, no pulse.
- prev press from cursor=0 -> cursor=15; 1 next -> 0. Sixteen up presses on step 5 -> 15 (saturated); one down press on step 3 at 0 -> stays 0.
- btn_next and btn_up released into the debouncers on the same cycle -> only cursor+1; pitch unchanged. clear+up together -> clear wins.
- Pattern 0x...FEDCBA9876543210, btn_clear -> busy high 16 cycles; step k zero from cycle k+1; beats=0 after; up press during busy ignored.
- rst asserted while idx=7 in CLEAR -> beats=INIT_PATTERN, busy=0, cursor=0 immediately (async). Also cursor=3, beat_count=3 -> on_playhead=1; beat_count=4 -> 0.
